regwrite_trace_buffer: RTL and testbench

REGWRITE_TRACE_BUFFER -- requirements
Module: regwrite_trace_buffer

---
 rtl/regwrite_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_regwrite_trace_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_trace_buffer.sv
// ---------------------------------------------------------------------------
// regwrite_trace_buffer
//   Captures register-file write-back events into a small show-ahead FIFO.
//   Each entry holds the PC, destination register, written data and the
//   free-running cycle timestamp of the cycle in which the write occurred.
//
//   WRAP = 0 : when full, new events are discarded and counted as drops.
//   WRAP = 1 : when full, the oldest entry is overwritten and counted as a drop.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   enable     capture enable (popping is unaffected)
//   clear      synchronous flush of entries and drop counter
//   wb_valid   register-file write strobe
//   wb_pc      PC of the writing instruction
//   wb_rd      destination register index
//   wb_data    data written to the register file
//   rd_mask    per-register capture enable, bit n enables xn
//   tr_valid   head entry available
//   tr_ready   consumer accepts head entry
//   tr_pc/tr_rd/tr_data/tr_stamp  head entry fields (don't-care when !tr_valid)
//   count      number of stored entries
//   full       count == DEPTH
//   drop_cnt   number of lost events, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module regwrite_trace_buffer #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 16,
   parameter int WRAP    = 0,
   parameter int SKIP_X0 = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic [31:0]              rd_mask,
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [XLEN-1:0]          tr_pc,
   output logic [4:0]               tr_rd,
   output logic [XLEN-1:0]          tr_data,
   output logic [TS_W-1:0]          tr_stamp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic [15:0]              drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Saturating increment for the drop counter.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [TS_W-1:0]  ts_q,     ts_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [15:0]      drop_q,   drop_d;

   logic [XLEN-1:0]  mem_pc_q    [DEPTH];
   logic [4:0]       mem_rd_q    [DEPTH];
   logic [XLEN-1:0]  mem_data_q  [DEPTH];
   logic [TS_W-1:0]  mem_stamp_q [DEPTH];

   logic capture;
   logic pop;
   logic is_full;
   logic is_x0_skip;
   logic wr_en;

   always_comb begin
      is_x0_skip = (SKIP_X0 != 0) && (wb_rd == 5'd0);
      capture    = enable & wb_valid & rd_mask[wb_rd] & ~is_x0_skip;
      tr_valid   = (count_q != '0);
      pop        = tr_valid & tr_ready;
      is_full    = (count_q == CNT_W'(DEPTH));

      ts_d     = ts_q + TS_W'(1);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      wr_en    = 1'b0;

      if (clear) begin
         // Flush wins over any capture or pop in the same cycle.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = '0;
      end else if (capture && is_full && !pop) begin
         drop_d = sat_inc(drop_q);
         if (WRAP != 0) begin
            // When full the write pointer sits on the oldest entry, so the
            // write overwrites it and the read pointer steps past it.
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
      end else begin
         // A pop frees a slot first, so a capture is always accepted here.
         if (capture) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (capture && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !capture) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         ts_q     <= ts_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Entry storage carries no reset; contents are only visible while valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc_q[wr_ptr_q]    <= wb_pc;
         mem_rd_q[wr_ptr_q]    <= wb_rd;
         mem_data_q[wr_ptr_q]  <= wb_data;
         mem_stamp_q[wr_ptr_q] <= ts_q;
      end
   end

   assign tr_pc    = mem_pc_q[rd_ptr_q];
   assign tr_rd    = mem_rd_q[rd_ptr_q];
   assign tr_data  = mem_data_q[rd_ptr_q];
   assign tr_stamp = mem_stamp_q[rd_ptr_q];
   assign count    = count_q;
   assign full     = is_full;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_regwrite_trace_buffer
//   Drives one stop-on-full instance and one circular instance (DEPTH=4) with
//   identical stimulus and checks both against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_regwrite_trace_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [15:0] stamp;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        clear = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_pc = '0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic [31:0] rd_mask = '1;
   logic        tr_ready = 1'b0;

   logic        s_tr_valid, c_tr_valid;
   logic [31:0] s_tr_pc, c_tr_pc, s_tr_data, c_tr_data;
   logic [4:0]  s_tr_rd, c_tr_rd;
   logic [15:0] s_tr_stamp, c_tr_stamp;
   logic [2:0]  s_count, c_count;
   logic        s_full, c_full;
   logic [15:0] s_drop, c_drop;

   ent_t s_head, c_head;
   assign s_head = {s_tr_pc, s_tr_rd, s_tr_data, s_tr_stamp};
   assign c_head = {c_tr_pc, c_tr_rd, c_tr_data, c_tr_stamp};

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   ent_t        q0[$];
   ent_t        q1[$];
   logic [15:0] mdrop0 = '0;
   logic [15:0] mdrop1 = '0;
   logic [15:0] mts = '0;

   always #5 clk = ~clk;

   regwrite_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .TS_W(16), .WRAP(0), .SKIP_X0(1)) u_stop (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .wb_valid(wb_valid),
      .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .rd_mask(rd_mask),
      .tr_valid(s_tr_valid), .tr_ready(tr_ready), .tr_pc(s_tr_pc), .tr_rd(s_tr_rd),
      .tr_data(s_tr_data), .tr_stamp(s_tr_stamp), .count(s_count), .full(s_full),
      .drop_cnt(s_drop));

   regwrite_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .TS_W(16), .WRAP(1), .SKIP_X0(1)) u_circ (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .wb_valid(wb_valid),
      .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .rd_mask(rd_mask),
      .tr_valid(c_tr_valid), .tr_ready(tr_ready), .tr_pc(c_tr_pc), .tr_rd(c_tr_rd),
      .tr_data(c_tr_data), .tr_stamp(c_tr_stamp), .count(c_count), .full(c_full),
      .drop_cnt(c_drop));

   function automatic logic [15:0] m_sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // One clock edge of the behavioural model, using the inputs as currently driven.
   task automatic model_step();
      bit   cap;
      ent_t e;
      cap = enable && wb_valid && rd_mask[wb_rd] && (wb_rd != 5'd0);
      e   = {wb_pc, wb_rd, wb_data, mts};
      if (clear) begin
         q0.delete(); q1.delete(); mdrop0 = '0; mdrop1 = '0;
      end else begin
         if (q0.size() > 0 && tr_ready) void'(q0.pop_front());
         if (q1.size() > 0 && tr_ready) void'(q1.pop_front());
         if (cap) begin
            if (q0.size() == DEPTH) mdrop0 = m_sat(mdrop0);
            else q0.push_back(e);
            if (q1.size() == DEPTH) begin
               void'(q1.pop_front());
               mdrop1 = m_sat(mdrop1);
            end
            q1.push_back(e);
         end
      end
      mts = mts + 16'd1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid = 1'b0; clear = 1'b0; tr_ready = 1'b0; enable = 1'b1; rd_mask = '1;
   endtask

   task automatic set_cap(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] data);
      wb_valid = 1'b1; wb_rd = rd; wb_pc = pc; wb_data = data;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #2;
      vectors++; if (s_tr_valid !== 1'b0) begin miscompares++; $display("FAIL reset.s_tr_valid got %b exp 0", s_tr_valid); end
      vectors++; if (s_count !== 3'd0) begin miscompares++; $display("FAIL reset.s_count got %0d exp 0", s_count); end
      vectors++; if (c_full !== 1'b0) begin miscompares++; $display("FAIL reset.c_full got %b exp 0", c_full); end
      vectors++; if (c_drop !== 16'd0) begin miscompares++; $display("FAIL reset.c_drop got %0d exp 0", c_drop); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      q0.delete(); q1.delete(); mdrop0 = '0; mdrop1 = '0; mts = '0;
   endtask

   task automatic test_single_capture();
      idle();
      tick(); tick(); tick();
      set_cap(5'd5, 32'h10, 32'hAB);
      tick();
      idle();
      vectors++; if (s_tr_valid !== 1'b1) begin miscompares++; $display("FAIL single.tr_valid got %b exp 1", s_tr_valid); end
      vectors++; if (s_tr_rd !== 5'd5) begin miscompares++; $display("FAIL single.tr_rd got %0d exp 5", s_tr_rd); end
      vectors++; if (s_tr_pc !== 32'h10) begin miscompares++; $display("FAIL single.tr_pc got %h exp 10", s_tr_pc); end
      vectors++; if (s_tr_data !== 32'hAB) begin miscompares++; $display("FAIL single.tr_data got %h exp ab", s_tr_data); end
      vectors++; if (s_tr_stamp !== 16'd3) begin miscompares++; $display("FAIL single.tr_stamp got %0d exp 3", s_tr_stamp); end
      vectors++; if (s_count !== 3'd1) begin miscompares++; $display("FAIL single.count got %0d exp 1", s_count); end
      vectors++; if (c_head !== {32'h10, 5'd5, 32'hAB, 16'd3}) begin miscompares++; $display("FAIL single.c_head got %h exp %h", c_head, {32'h10, 5'd5, 32'hAB, 16'd3}); end
      tr_ready = 1'b1;
      tick();
      idle();
      vectors++; if (s_count !== 3'd0 || s_tr_valid !== 1'b0) begin miscompares++; $display("FAIL single.drain got count %0d valid %b exp 0 0", s_count, s_tr_valid); end
   endtask

   task automatic test_x0_filter();
      idle();
      set_cap(5'd0, 32'h20, 32'h1);
      tick();
      vectors++; if (s_count !== 3'd0) begin miscompares++; $display("FAIL x0.count got %0d exp 0", s_count); end
      rd_mask = 32'hFFFF_FF7F;
      set_cap(5'd7, 32'h24, 32'h2);
      tick();
      idle();
      vectors++; if (s_count !== 3'd0 || c_count !== 3'd0) begin miscompares++; $display("FAIL mask7.count got %0d/%0d exp 0", s_count, c_count); end
      vectors++; if (s_drop !== 16'd0) begin miscompares++; $display("FAIL mask7.drop got %0d exp 0", s_drop); end
   endtask

   task automatic test_fill_and_wrap();
      logic [31:0] exp_s [4];
      logic [31:0] exp_c [4];
      exp_s = '{32'd1, 32'd2, 32'd3, 32'd4};
      exp_c = '{32'd3, 32'd4, 32'd5, 32'd6};
      idle();
      for (int i = 1; i <= 6; i++) begin
         set_cap(5'(i), 32'h100 + 32'(i), 32'(i));
         tick();
      end
      idle();
      vectors++; if (s_full !== 1'b1 || s_count !== 3'd4) begin miscompares++; $display("FAIL stopfull.full/count got %b/%0d exp 1/4", s_full, s_count); end
      vectors++; if (s_drop !== 16'd2) begin miscompares++; $display("FAIL stopfull.drop got %0d exp 2", s_drop); end
      vectors++; if (c_count !== 3'd4 || c_drop !== 16'd2) begin miscompares++; $display("FAIL circ.count/drop got %0d/%0d exp 4/2", c_count, c_drop); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (s_tr_data !== exp_s[i]) begin miscompares++; $display("FAIL stopfull.pop%0d got %0d exp %0d", i, s_tr_data, exp_s[i]); end
         vectors++; if (c_tr_data !== exp_c[i]) begin miscompares++; $display("FAIL circ.pop%0d got %0d exp %0d", i, c_tr_data, exp_c[i]); end
         tr_ready = 1'b1;
         tick();
      end
      idle();
      vectors++; if (s_count !== 3'd0 || c_count !== 3'd0) begin miscompares++; $display("FAIL fill.drain got %0d/%0d exp 0", s_count, c_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [4];
      exp_d = '{32'd12, 32'd13, 32'd14, 32'd9};
      idle();
      for (int i = 11; i <= 14; i++) begin
         set_cap(5'd3, 32'h200, 32'(i));
         tick();
      end
      set_cap(5'd3, 32'h200, 32'd9);
      tr_ready = 1'b1;
      tick();
      idle();
      vectors++; if (s_count !== 3'd4 || s_drop !== 16'd2) begin miscompares++; $display("FAIL pushpop.count/drop got %0d/%0d exp 4/2", s_count, s_drop); end
      vectors++; if (c_count !== 3'd4 || c_drop !== 16'd2) begin miscompares++; $display("FAIL pushpop.c_count/drop got %0d/%0d exp 4/2", c_count, c_drop); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (s_tr_data !== exp_d[i] || c_tr_data !== exp_d[i]) begin miscompares++; $display("FAIL pushpop.pop%0d got %0d/%0d exp %0d", i, s_tr_data, c_tr_data, exp_d[i]); end
         tr_ready = 1'b1;
         tick();
      end
      idle();
   endtask

   task automatic test_clear();
      idle();
      set_cap(5'd1, 32'h300, 32'h31); tick();
      set_cap(5'd2, 32'h304, 32'h32); tick();
      set_cap(5'd3, 32'h308, 32'h55);
      clear = 1'b1;
      tick();
      idle();
      vectors++; if (s_count !== 3'd0 || s_tr_valid !== 1'b0) begin miscompares++; $display("FAIL clear.count/valid got %0d/%b exp 0/0", s_count, s_tr_valid); end
      vectors++; if (s_drop !== 16'd0 || c_drop !== 16'd0) begin miscompares++; $display("FAIL clear.drop got %0d/%0d exp 0", s_drop, c_drop); end
      tick();
      vectors++; if (c_count !== 3'd0 || c_tr_valid !== 1'b0) begin miscompares++; $display("FAIL clear.stored got %0d/%b exp 0/0", c_count, c_tr_valid); end
   endtask

   task automatic test_reset_midpop();
      idle();
      for (int i = 1; i <= 5; i++) begin
         set_cap(5'(i), 32'h400, 32'(i));
         tick();
      end
      idle();
      tr_ready = 1'b1;
      #2 reset = 1'b0;
      #1;
      vectors++; if (s_count !== 3'd0 || s_full !== 1'b0 || s_tr_valid !== 1'b0) begin miscompares++; $display("FAIL rstpop.s got count %0d full %b valid %b exp 0", s_count, s_full, s_tr_valid); end
      vectors++; if (s_drop !== 16'd0 || c_drop !== 16'd0) begin miscompares++; $display("FAIL rstpop.drop got %0d/%0d exp 0", s_drop, c_drop); end
      vectors++; if (c_count !== 3'd0 || c_tr_valid !== 1'b0) begin miscompares++; $display("FAIL rstpop.c got count %0d valid %b exp 0", c_count, c_tr_valid); end
      q0.delete(); q1.delete(); mdrop0 = '0; mdrop1 = '0; mts = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle();
      set_cap(5'd9, 32'h500, 32'h77);
      tick();
      idle();
      vectors++; if (s_tr_stamp !== 16'd0 || s_tr_data !== 32'h77) begin miscompares++; $display("FAIL rstpop.restart got stamp %0d data %h exp 0 77", s_tr_stamp, s_tr_data); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         enable   = ($urandom_range(0, 7) != 0);
         clear    = ($urandom_range(0, 40) == 0);
         wb_valid = ($urandom_range(0, 3) != 0);
         wb_rd    = 5'($urandom_range(0, 31));
         wb_pc    = $urandom();
         wb_data  = $urandom();
         rd_mask  = $urandom() | $urandom();
         tr_ready = ($urandom_range(0, 2) == 0);
         tick();
         vectors++; if (s_count !== 3'(q0.size()) || s_full !== (q0.size() == DEPTH)) begin miscompares++; $display("FAIL rand%0d.s_count got %0d full %b exp %0d", n, s_count, s_full, q0.size()); end
         vectors++; if (c_count !== 3'(q1.size()) || c_full !== (q1.size() == DEPTH)) begin miscompares++; $display("FAIL rand%0d.c_count got %0d full %b exp %0d", n, c_count, c_full, q1.size()); end
         vectors++; if (s_drop !== mdrop0 || c_drop !== mdrop1) begin miscompares++; $display("FAIL rand%0d.drop got %0d/%0d exp %0d/%0d", n, s_drop, c_drop, mdrop0, mdrop1); end
         vectors++; if (s_tr_valid !== (q0.size() > 0) || c_tr_valid !== (q1.size() > 0)) begin miscompares++; $display("FAIL rand%0d.valid got %b/%b exp %0d/%0d", n, s_tr_valid, c_tr_valid, q0.size(), q1.size()); end
         if (q0.size() > 0) begin
            vectors++; if (s_head !== q0[0]) begin miscompares++; $display("FAIL rand%0d.s_head got %h exp %h", n, s_head, q0[0]); end
         end
         if (q1.size() > 0) begin
            vectors++; if (c_head !== q1[0]) begin miscompares++; $display("FAIL rand%0d.c_head got %h exp %h", n, c_head, q1[0]); end
         end
      end
      idle();
   endtask

   task automatic test_drop_saturate();
      idle();
      clear = 1'b1;
      tick();
      idle();
      for (int n = 0; n < 65545; n++) begin
         set_cap(5'(1 + (n % 31)), 32'(n), 32'(n * 3));
         tick();
      end
      idle();
      vectors++; if (s_drop !== 16'hFFFF || s_count !== 3'd4) begin miscompares++; $display("FAIL sat.s got drop %h count %0d exp ffff 4", s_drop, s_count); end
      vectors++; if (c_drop !== 16'hFFFF || c_count !== 3'd4) begin miscompares++; $display("FAIL sat.c got drop %h count %0d exp ffff 4", c_drop, c_count); end
      vectors++; if (s_head !== q0[0] || c_head !== q1[0]) begin miscompares++; $display("FAIL sat.head got %h/%h exp %h/%h", s_head, c_head, q0[0], q1[0]); end
      clear = 1'b1;
      tick();
      idle();
      vectors++; if (s_drop !== 16'd0 || c_drop !== 16'd0) begin miscompares++; $display("FAIL sat.clear got %h/%h exp 0", s_drop, c_drop); end
   endtask

   initial begin
      test_reset();
      test_single_capture();
      test_x0_filter();
      test_fill_and_wrap();
      test_back_to_back();
      test_clear();
      test_reset_midpop();
      test_random();
      test_drop_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
